// File: rtl/egress_drain_if.sv
// Merged egress output stream: valid/ready handshake carrying a word
// and the index of the egress port it was drained from.
interface egress_drain_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] data_out;
  logic [1:0]       src_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output data_out,
    output src_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  src_out,
    input  valid_out,
    output ready_in
  );
endinterface

// File: rtl/egress_drain.sv
// Round-robin drain of four egress FIFOs onto one valid/ready stream,
// with a 2-entry buffer absorbing the one-cycle FIFO read latency.
module egress_drain #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fifo4_out,
  input  logic [WIDTH-1:0] fifo5_out,
  input  logic [WIDTH-1:0] fifo6_out,
  input  logic [WIDTH-1:0] fifo7_out,
  input  logic             empty4,
  input  logic             empty5,
  input  logic             empty6,
  input  logic             empty7,
  output logic             pop4,
  output logic             pop5,
  output logic             pop6,
  output logic             pop7,
  egress_drain_if.master   strm,
  output logic [CNT_W-1:0] cnt4,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt6,
  output logic [CNT_W-1:0] cnt7,
  output logic             err_dest,
  output logic [1:0]       err_src
);

  typedef struct packed {
    logic [1:0]       src;
    logic [WIDTH-1:0] word;
  } ent_t;

  logic [1:0]       rr;
  logic             infl;
  logic [1:0]       infl_src;
  ent_t             buf_q [2];
  logic [1:0]       occ;
  logic [CNT_W-1:0] cnt_q [4];

  logic [3:0]       empty;
  logic [3:0]       pop;
  logic [WIDTH-1:0] fdata [4];
  logic             accept;
  logic             credit;
  logic [2:0]       load;
  logic             found;
  logic             grant;
  logic [1:0]       gidx;
  logic [1:0]       cand;
  ent_t             cap_ent;
  ent_t             b0_n;
  ent_t             b1_n;
  logic [1:0]       occ_mid;
  logic [1:0]       occ_n;

  assign empty    = {empty7, empty6, empty5, empty4};
  assign fdata[0] = fifo4_out;
  assign fdata[1] = fifo5_out;
  assign fdata[2] = fifo6_out;
  assign fdata[3] = fifo7_out;
  assign {pop7, pop6, pop5, pop4} = pop;

  assign strm.valid_out = (occ != 2'd0);
  assign strm.data_out  = buf_q[0].word;
  assign strm.src_out   = buf_q[0].src;
  assign accept = strm.valid_out && strm.ready_in;

  assign cnt4 = cnt_q[0];
  assign cnt5 = cnt_q[1];
  assign cnt6 = cnt_q[2];
  assign cnt7 = cnt_q[3];

  // accept implies occ >= 1, so the subtraction cannot underflow
  assign load   = {1'b0, occ} + {2'b00, infl};
  assign credit = (load - {2'b00, accept}) < 3'd2;

  always_comb begin
    found = 1'b0;
    gidx  = rr;
    cand  = rr;
    for (int i = 0; i < 4; i++) begin
      cand = rr + 2'(i);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    grant = found && credit && !reset;
    pop   = 4'b0000;
    if (grant) pop[gidx] = 1'b1;
  end

  always_comb begin
    cap_ent.src  = infl_src;
    cap_ent.word = fdata[infl_src];
    b0_n    = buf_q[0];
    b1_n    = buf_q[1];
    occ_mid = occ - {1'b0, accept};
    if (accept) b0_n = buf_q[1];
    if (infl) begin
      if (occ_mid == 2'd0) b0_n = cap_ent;
      else                 b1_n = cap_ent;
    end
    occ_n = occ_mid + {1'b0, infl};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr       <= 2'd0;
      infl     <= 1'b0;
      infl_src <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      occ      <= 2'd0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      err_dest <= 1'b0;
      err_src  <= 2'd0;
    end else begin
      if (grant) rr <= gidx + 2'd1;
      infl     <= grant;
      infl_src <= gidx;
      buf_q[0] <= b0_n;
      buf_q[1] <= b1_n;
      occ      <= occ_n;
      if (accept)
        cnt_q[buf_q[0].src] <= cnt_q[buf_q[0].src] + 1'b1;
      if (infl && cap_ent.word[WIDTH-1:WIDTH-2] != infl_src) begin
        err_dest <= 1'b1;
        if (!err_dest) err_src <= infl_src;
      end
    end
  end

endmodule

// File: tb/tb_egress_drain.sv
// Directed bench for egress_drain: behavioural FIFOs feed the four ports,
// a monitor logs pops and accepted words, checks compare to fixed tables.
module tb_egress_drain;
  localparam int W = 10;
  localparam int C = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  egress_drain_if #(.WIDTH(W)) bus ();

  logic [W-1:0] fo [4];
  logic [3:0]   empty;
  logic         pop4, pop5, pop6, pop7;
  logic [C-1:0] cnt [4];
  logic         err_dest;
  logic [1:0]   err_src;
  wire  [3:0]   pops = {pop7, pop6, pop5, pop4};

  egress_drain #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset),
    .fifo4_out(fo[0]), .fifo5_out(fo[1]),
    .fifo6_out(fo[2]), .fifo7_out(fo[3]),
    .empty4(empty[0]), .empty5(empty[1]),
    .empty6(empty[2]), .empty7(empty[3]),
    .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
    .strm(bus.master),
    .cnt4(cnt[0]), .cnt5(cnt[1]), .cnt6(cnt[2]), .cnt7(cnt[3]),
    .err_dest(err_dest), .err_src(err_src)
  );

  // FIFO models: data appears the cycle after a pop
  logic [W-1:0] fm [4][64];
  int rd [4] = '{0, 0, 0, 0};
  int wr [4] = '{0, 0, 0, 0};

  for (genvar g = 0; g < 4; g++) begin : g_empty
    assign empty[g] = (rd[g] == wr[g]);
  end

  initial for (int i = 0; i < 4; i++) fo[i] = '0;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pops[i] && rd[i] != wr[i]) begin
        fo[i] <= fm[i][rd[i]];
        rd[i] <= rd[i] + 1;
      end
    end
  end

  task automatic push(input int p, input logic [W-1:0] w);
    fm[p][wr[p]] = w;
    wr[p] = wr[p] + 1;
  endtask

  int          cyc = 0;
  logic        pop_bad = 1'b0;
  int          popq [$];
  int          popc [$];
  logic [11:0] outq [$];
  int          outc [$];

  always @(negedge clk) begin
    #2;
    cyc = cyc + 1;
    if ($countones(pops) > 1) pop_bad = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (pops[i]) begin
        if (empty[i]) pop_bad = 1'b1;
        popq.push_back(i);
        popc.push_back(cyc);
      end
    end
    if (bus.valid_out && bus.ready_in) begin
      outq.push_back({bus.src_out, bus.data_out});
      outc.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [W-1:0] wd(input int p, input int k);
    return {2'(p), 8'(16 * p + k)};
  endfunction

  task automatic clear_log();
    popq.delete(); popc.delete();
    outq.delete(); outc.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic [11:0] exp [$]);
    chk({nm, "_count"}, outq.size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_word%0d", nm, k),
          (k < outq.size()) ? int'(outq[k]) : -1, int'(exp[k]));
  endtask

  task automatic seq_cnt(input string nm, input int q [$], input int n);
    for (int k = 1; k < n; k++)
      chk($sformatf("%s_cyc%0d", nm, k),
          (k < q.size()) ? q[k] - q[0] : -1, k);
  endtask

  typedef struct {
    int         port;
    logic [W-1:0] word;
    logic       exp_err;
    logic [1:0] exp_esrc;
  } vec_t;

  vec_t        vt [6];
  logic [11:0] exp8 [$];
  logic [11:0] exp2 [$];

  initial begin
    vt[0] = '{port: 0, word: 10'h0A5, exp_err: 1'b0, exp_esrc: 2'd0};
    vt[1] = '{port: 1, word: 10'h155, exp_err: 1'b0, exp_esrc: 2'd0};
    vt[2] = '{port: 2, word: 10'h2AA, exp_err: 1'b0, exp_esrc: 2'd0};
    vt[3] = '{port: 3, word: 10'h3C3, exp_err: 1'b0, exp_esrc: 2'd0};
    vt[4] = '{port: 2, word: 10'h3FF, exp_err: 1'b1, exp_esrc: 2'd2};
    vt[5] = '{port: 1, word: 10'h0F0, exp_err: 1'b1, exp_esrc: 2'd1};

    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++)
        exp8.push_back({2'(p), wd(p, k)});

    // reset held with every FIFO loaded
    bus.ready_in = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) push(p, wd(p, k));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("rst_pops", int'(pops), 0);
      chk("rst_valid", int'(bus.valid_out), 0);
      chk("rst_cnt", int'(cnt[0] | cnt[1] | cnt[2] | cnt[3]), 0);
    end
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_src", int'(bus.src_out), 0);
    chk("rst_err", int'({err_dest, err_src}), 0);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    #1;
    chk("first_pop4", int'(pops), 1);

    // full throughput across all four ports
    repeat (12) @(negedge clk);
    chk("rr_pop_count", popq.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_pop%0d", k),
          (k < popq.size()) ? popq[k] : -1, k % 4);
    seq_cnt("rr_popcyc", popc, 8);
    check_out("rr_out", exp8);
    seq_cnt("rr_outcyc", outc, 8);
    chk("rr_latency",
        (outc.size() > 0 && popc.size() > 0) ? outc[0] - popc[0] : -1, 2);
    for (int p = 0; p < 4; p++)
      chk($sformatf("rr_cnt%0d", p + 4), int'(cnt[p]), 2);

    // backpressure: only two words may be outstanding
    bus.ready_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) push(p, wd(p, k));
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.valid_out) begin
        chk("bp_hold_data", int'(bus.data_out), int'(wd(0, 0)));
        chk("bp_hold_src", int'(bus.src_out), 0);
      end
    end
    chk("bp_valid", int'(bus.valid_out), 1);
    chk("bp_pop_count", popq.size(), 2);
    chk("bp_pop0", (popq.size() > 0) ? popq[0] : -1, 0);
    chk("bp_pop1", (popq.size() > 1) ? popq[1] : -1, 1);
    bus.ready_in = 1'b1;
    repeat (14) @(negedge clk);
    check_out("bp_out", exp8);
    for (int p = 0; p < 4; p++)
      chk($sformatf("bp_cnt%0d", p + 4), int'(cnt[p]), 2);

    // one word per vector: latency, tagging and dest check
    for (int v = 0; v < 6; v++) begin
      pulse_reset();
      clear_log();
      push(vt[v].port, vt[v].word);
      #1;
      chk($sformatf("v%0d_pop", v), int'(pops), 1 << vt[v].port);
      @(negedge clk); #1;
      chk($sformatf("v%0d_t1_valid", v), int'(bus.valid_out), 0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_t2_valid", v), int'(bus.valid_out), 1);
      chk($sformatf("v%0d_data", v), int'(bus.data_out), int'(vt[v].word));
      chk($sformatf("v%0d_src", v), int'(bus.src_out), vt[v].port);
      @(negedge clk); #1;
      chk($sformatf("v%0d_cnt", v), int'(cnt[vt[v].port]), 1);
      chk($sformatf("v%0d_err", v), int'(err_dest), int'(vt[v].exp_err));
      chk($sformatf("v%0d_esrc", v), int'(err_src), int'(vt[v].exp_esrc));
    end

    // two bad words: err_src keeps the first
    pulse_reset();
    clear_log();
    push(2, 10'h3FF);
    @(negedge clk);
    push(0, 10'h1AB);
    repeat (6) @(negedge clk);
    chk("err_dest", int'(err_dest), 1);
    chk("err_first_src", int'(err_src), 2);
    exp2.delete();
    exp2.push_back({2'd2, 10'h3FF});
    exp2.push_back({2'd0, 10'h1AB});
    check_out("err_out", exp2);

    // reset lands while a pop5 word is returning
    pulse_reset();
    clear_log();
    push(1, wd(1, 5));
    #1;
    chk("rp_pop5", int'(pops), 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    push(3, wd(3, 0));
    push(0, wd(0, 7));
    #1;
    chk("rp_grant4", int'(pops), 1);
    chk("rp_valid0", int'(bus.valid_out), 0);
    @(negedge clk); #1;
    chk("rp_valid1", int'(bus.valid_out), 0);
    repeat (5) @(negedge clk);
    exp2.delete();
    exp2.push_back({2'd0, wd(0, 7)});
    exp2.push_back({2'd3, wd(3, 0)});
    check_out("rp_out", exp2);
    chk("rp_cnt5", int'(cnt[1]), 0);
    chk("rp_cnt4", int'(cnt[0]), 1);
    chk("rp_valid_end", int'(bus.valid_out), 0);

    chk("pop_legal", int'(pop_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/egress_drain.md
# egress_drain

Downstream stage of the 4x4 switch: drains the four egress FIFOs (ports 4..7) through a round-robin pop arbiter and merges them onto a single valid/ready output stream. It accounts for the FIFOs' one-cycle read latency with a 2-entry output buffer. It also keeps per-port delivered-word counters and flags words whose destination field does not match the port they left from.

## Interface
- WIDTH, 10, word width; bits [WIDTH-1:WIDTH-2] carry the destination port index.
- CNT_W, 16, width of each per-port delivered-word counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset (sampled on posedge clk).
- fifo4_out, fifo5_out, fifo6_out, fifo7_out  in  WIDTH  egress FIFO read data; valid the cycle after the matching pop.
- empty4, empty5, empty6, empty7  in  1  egress FIFO empty flags; reflect all pops up to the previous edge.
- pop4, pop5, pop6, pop7  out  1  FIFO pop strobes; at most one asserted per cycle.
- data_out  out  WIDTH  merged output word (buffer head).
- src_out  out  2  source port of data_out (0=port4 .. 3=port7).
- valid_out  out  1  data_out/src_out valid.
- ready_in  in  1  downstream accepts when valid_out && ready_in at the edge.
- cnt4, cnt5, cnt6, cnt7  out  CNT_W  words accepted downstream per source port.
- err_dest  out  1  sticky: a captured word had dest field != source index.
- err_src  out  2  source index of the first mismatching word.

## Operation
- Registered state:
  - rr pointer (2 b);
  - inflight flag plus inflight source (2 b);
  - 2-entry buffer of {src, word} with occupancy occ (0..2);
  - counters and error flags.
- Credit: accept = valid_out && ready_in. A pop is allowed when occ + inflight - accept < 2.
- Arbitration, combinational from state, emptyN and ready_in:
  - When credit is allowed, grant the first non-empty port scanning rr, rr+1, ... mod 4.
  - Assert the matching popN.
  - Set rr <= granted+1 mod 4.
  - With no grant, rr holds.
- Pops are never issued to a FIFO with emptyN=1.
- Capture: when inflight is set, the word on fifo(4+inflight_src)_out is written to the buffer tail at the next edge.
  - Simultaneous capture and accept are legal: occ is unchanged and the head advances.
- Dest check on capture: if word[WIDTH-1:WIDTH-2] != source index, set err_dest. The word is still forwarded.
  - err_src records the source only on the first error, i.e. while err_dest=0.
- On accept, cnt(4+src_out) increments, wrapping modulo 2^CNT_W.
- Order within one source is preserved. Order across sources follows grant order.
- Reset (synchronous, any cycle):
  - Clears rr=0, inflight=0, occ=0, counters=0, err_dest=0, err_src=0.
  - A word returning from a pop issued the cycle before reset is discarded.
  - No pops are asserted while reset=1.

## Timing
- Reset values: pop4..7=0, valid_out=0, data_out=0, src_out=0, cnt4..7=0, err_dest=0, err_src=0.
- Pop issued in cycle t:
  - the FIFO data is present in t+1;
  - it is captured at the end of t+1;
  - valid_out is high in t+2. Pop-to-valid latency is 2 cycles.
- Throughput is one word per cycle with ready_in held high and at least one non-empty FIFO.
- With ready_in=0, at most 2 words are ever popped and outstanding. No loss, no overwrite.
- data_out/src_out are stable while valid_out && !ready_in.
- popN is combinational. Downstream must not combinationally route popN back into ready_in.
- All FIFOs empty: no pops; valid_out falls after the buffer drains.

## Test plan
- Hold reset 3 cycles with all FIFOs non-empty -> no popN, valid_out=0, all counters 0. After release, pop4 is asserted in the first cycle.
- Only fifo4 holds 0x0A5, dest 00, pop in cycle t with ready_in=1:
  - pop4 is asserted in t only;
  - in t+2: valid_out=1, data_out=0x0A5, src_out=0;
  - then cnt4=1.
- All four FIFOs hold 2 correctly tagged words each, ready_in=1 -> pops in order 4,5,6,7,4,5,6,7 on 8 consecutive cycles, 8 consecutive valid_out cycles, cnt4..7=2 each.
- Same load with ready_in=0 for 10 cycles, then 1:
  - exactly 2 pops (port4, port5), then pops stop;
  - valid_out is held with port4's word;
  - after release, all 8 words arrive in grant order with none lost.
- fifo6 holds 0x3FF (dest 3, source 2), followed by fifo4 holding 0x1xx (dest 1, source 0) -> err_dest=1, err_src=2 (not 0), and both words are still delivered.
- Assert reset one cycle after a pop5 -> the returning word is not captured, occ=0, valid_out=0, and the first post-reset grant is port4 (rr=0).
